core_run_ctrl: RTL and testbench

Run controller for the single-cycle core. Accepts a program as a stream of 32-bit words and writes it into instruction memory while holding the core in reset. It then releases the core and monitors the fetched instruction and PC. It stops the core on a halt instruction, a PC past the loaded image, or a cycle-budget timeout, and reports the cause and cycle count.

---
 rtl/core_run_ctrl.sv | 156 +++++++++++++++
 tb/tb_core_run_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// Run controller: streams a program into imem with the core held in reset,
// then runs the core until halt instruction, PC escape, timeout or abort.
module core_run_ctrl #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          ADDR_W     = 6,
  parameter int          CNT_W      = 16,
  parameter int          MAX_CYCLES = 1000,
  parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  input  logic [31:0]       core_instr,
  input  logic [31:0]       core_pc,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [ADDR_W:0]   loaded_words,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_HALT
  } state_e;

  localparam logic [ADDR_W:0] LAST_IDX =
    (ADDR_W+1)'(IMEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              crst_q, crst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        cause_q, cause_d;
  logic [ADDR_W:0]   lw_q, lw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pc_oob;

  assign pc_oob = (core_pc[31:2] >= 30'(lw_q)) ||
                  (core_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lw_d    = lw_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (abort) begin
      state_d = S_IDLE;
      cause_d = 2'b00;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_d = S_LOAD;
            lw_d    = '0;
            cnt_d   = '0;
            cause_d = 2'b00;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            we_d    = 1'b1;
            addr_d  = lw_q[ADDR_W-1:0];
            wdata_d = load_data;
            lw_d    = lw_q + 1'b1;
            if (load_last || lw_q == LAST_IDX)
              state_d = S_FLUSH;
          end
        end
        S_FLUSH: begin
          state_d = (lw_q == '0) ? S_IDLE : S_RUN;
        end
        S_RUN: begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          // Priority: halt instruction, then PC escape, then budget.
          if (core_instr == HALT_INSTR) begin
            state_d = S_HALT;
            cause_d = 2'b01;
          end else if (pc_oob) begin
            state_d = S_HALT;
            cause_d = 2'b10;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_HALT;
            cause_d = 2'b11;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    crst_d = (state_d != S_RUN);
    busy_d = (state_d == S_LOAD) || (state_d == S_FLUSH) ||
             (state_d == S_RUN);
    done_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
      lw_q    <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      lw_q    <= lw_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load_ready   = (state_q == S_LOAD);
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_reset   = crst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign halt_cause   = cause_q;
  assign loaded_words = lw_q;
  assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: scenario tasks checked against a
// sequence-level model of loading and run termination.
module tb_core_run_ctrl;

  localparam int MAXC = 12;
  localparam logic [31:0] HALT = 32'h00100073;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic        load_valid, load_last, load_ready;
  logic [31:0] load_data;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic [31:0] core_instr, core_pc;
  logic        busy, done;
  logic [1:0]  halt_cause;
  logic [6:0]  loaded_words;
  logic [15:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] img [64];
  logic [31:0] pcs [MAXC];
  logic [31:0] ins [MAXC];
  logic [37:0] wq [$];

  core_run_ctrl #(
    .IMEM_DEPTH(64), .ADDR_W(6), .CNT_W(16),
    .MAX_CYCLES(MAXC), .HALT_INSTR(HALT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset),
    .core_instr(core_instr), .core_pc(core_pc),
    .busy(busy), .done(done), .halt_cause(halt_cause),
    .loaded_words(loaded_words), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && imem_we) wq.push_back({imem_addr, imem_wdata});

  initial begin
    #300000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gapmode: 0 none, 1 one idle cycle between words, 2 random idles
  task automatic drive_load(input int n, input int gapmode,
                            input bit uselast, output bit ok);
    ok = 1'b1;
    wq.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (gapmode == 1 ||
          (gapmode == 2 && $urandom_range(0, 1) == 1))) begin
        load_valid = 1'b0;
        load_data  = $urandom;
        step();
      end
      load_valid = 1'b1;
      load_data  = img[i];
      load_last  = uselast && (i == n - 1);
      if (!load_ready) begin
        ok = 1'b0;
        break;
      end
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Feeds pcs/ins one RUN cycle at a time until done, with stray
  // start pulses that must be ignored.
  task automatic drive_run(output int steps);
    steps = 0;
    while (!done && steps < MAXC + 2) begin
      core_pc    = (steps < MAXC) ? pcs[steps] : 32'h0;
      core_instr = (steps < MAXC) ? ins[steps] : NOP;
      start      = ($urandom_range(0, 3) == 0);
      step();
      steps++;
    end
    start      = 1'b0;
    core_instr = NOP;
    core_pc    = 32'h0;
  endtask

  // Scan the per-cycle sequence for the first terminating condition.
  function automatic void model(input int n, output int cause,
                                output int cnt);
    cause = 0;
    cnt   = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (ins[c] == HALT) cause = 1;
      else if ((pcs[c] / 4) >= n || (pcs[c] % 4) != 0) cause = 2;
      else if (c == MAXC - 1) cause = 3;
      if (cause != 0) begin
        cnt = c + 1;
        return;
      end
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({load_ready, imem_we, imem_addr, imem_wdata, core_reset,
         busy, done, halt_cause, loaded_words, cycle_count} !==
        {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2'd0, 7'd0,
         16'd0}) begin
      n_err++;
      $display("FAIL reset_vals: rdy=%b we=%b a=%0d wd=%h crst=%b busy=%b done=%b cause=%0d lw=%0d cnt=%0d",
        load_ready, imem_we, imem_addr, imem_wdata, core_reset,
        busy, done, halt_cause, loaded_words, cycle_count);
    end
    reset = 1'b0;
    step();
    step();
    n_cmp++;
    if (core_reset !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: crst=%b busy=%b rdy=%b want 1 0 0",
        core_reset, busy, load_ready);
    end
  endtask

  task automatic test_halt_instr();
    bit ok;
    int st, ec, en;
    for (int i = 0; i < 3; i++) img[i] = NOP;
    img[3] = HALT;
    drive_load(4, 0, 1'b1, ok);
    n_cmp++;
    if (!ok || load_ready !== 1'b0 || busy !== 1'b1 ||
        core_reset !== 1'b1) begin
      n_err++;
      $display("FAIL hi_flush: ok=%b rdy=%b busy=%b crst=%b want 1 0 1 1",
        ok, load_ready, busy, core_reset);
    end
    step();
    n_cmp++;
    if (core_reset !== 1'b0) begin
      n_err++;
      $display("FAIL hi_crst_drop: got %b want 0", core_reset);
    end
    n_cmp++;
    if (wq.size() != 4 || loaded_words !== 7'd4) begin
      n_err++;
      $display("FAIL hi_writes: got %0d/%0d want 4/4",
        wq.size(), loaded_words);
    end
    for (int i = 0; i < wq.size() && i < 4; i++) begin
      n_cmp++;
      if (wq[i] !== {6'(i), img[i]}) begin
        n_err++;
        $display("FAIL hi_wr%0d: got %h want %h", i, wq[i],
          {6'(i), img[i]});
      end
    end
    for (int c = 0; c < MAXC; c++) begin
      pcs[c] = 4 * c;
      ins[c] = (c == 2) ? HALT : NOP;
    end
    drive_run(st);
    model(4, ec, en);
    n_cmp++;
    if (done !== 1'b1 || halt_cause !== 2'(ec) ||
        cycle_count !== 16'(en) || st != en) begin
      n_err++;
      $display("FAIL hi_end: done=%b cause=%0d cnt=%0d steps=%0d want 1 %0d %0d %0d",
        done, halt_cause, cycle_count, st, ec, en, en);
    end
  endtask

  task automatic test_pc_oob();
    bit ok;
    int st, ec, en;
    img[0] = NOP;
    img[1] = 32'h00a00093;
    drive_load(2, 2, 1'b1, ok);
    step();
    n_cmp++;
    if (!ok || core_reset !== 1'b0 || cycle_count !== 16'd0 ||
        halt_cause !== 2'd0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL oob_start: ok=%b crst=%b cnt=%0d cause=%0d done=%b want 1 0 0 0 0",
        ok, core_reset, cycle_count, halt_cause, done);
    end
    for (int c = 0; c < MAXC; c++) begin
      pcs[c] = 4 * c;
      ins[c] = NOP;
    end
    drive_run(st);
    model(2, ec, en);
    n_cmp++;
    if (done !== 1'b1 || halt_cause !== 2'(ec) ||
        cycle_count !== 16'(en) || st != en) begin
      n_err++;
      $display("FAIL oob_end: done=%b cause=%0d cnt=%0d steps=%0d want 1 %0d %0d %0d",
        done, halt_cause, cycle_count, st, ec, en, en);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int st, ec, en;
    img[0] = NOP;
    drive_load(1, 0, 1'b1, ok);
    step();
    for (int c = 0; c < MAXC; c++) begin
      pcs[c] = 32'h0;
      ins[c] = NOP;
    end
    drive_run(st);
    model(1, ec, en);
    n_cmp++;
    if (!ok || done !== 1'b1 || halt_cause !== 2'(ec) ||
        cycle_count !== 16'(en) || st != en) begin
      n_err++;
      $display("FAIL to_end: ok=%b done=%b cause=%0d cnt=%0d steps=%0d want 1 1 %0d %0d %0d",
        ok, done, halt_cause, cycle_count, st, ec, en, en);
    end
  endtask

  task automatic test_full_load();
    bit ok;
    int st, ec, en;
    for (int i = 0; i < 64; i++) img[i] = $urandom;
    drive_load(64, 1, 1'b0, ok);
    n_cmp++;
    if (!ok || load_ready !== 1'b0 || loaded_words !== 7'd64) begin
      n_err++;
      $display("FAIL full_end: ok=%b rdy=%b lw=%0d want 1 0 64",
        ok, load_ready, loaded_words);
    end
    load_valid = 1'b1;
    load_data  = 32'hdeadbeef;
    step();
    load_valid = 1'b0;
    n_cmp++;
    if (core_reset !== 1'b0 || load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_run: crst=%b rdy=%b want 0 0",
        core_reset, load_ready);
    end
    for (int c = 0; c < MAXC; c++) begin
      pcs[c] = (c == 4) ? 32'd18 : 4 * c;
      ins[c] = NOP;
    end
    drive_run(st);
    model(64, ec, en);
    n_cmp++;
    if (done !== 1'b1 || halt_cause !== 2'(ec) ||
        cycle_count !== 16'(en) || st != en) begin
      n_err++;
      $display("FAIL full_halt: done=%b cause=%0d cnt=%0d steps=%0d want 1 %0d %0d %0d",
        done, halt_cause, cycle_count, st, ec, en, en);
    end
    n_cmp++;
    if (wq.size() != 64) begin
      n_err++;
      $display("FAIL full_count: got %0d want 64", wq.size());
    end
    for (int i = 0; i < wq.size() && i < 64; i++) begin
      n_cmp++;
      if (wq[i] !== {6'(i), img[i]}) begin
        n_err++;
        $display("FAIL full_wr%0d: got %h want %h", i, wq[i],
          {6'(i), img[i]});
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    for (int i = 0; i < 3; i++) img[i] = NOP;
    drive_load(3, 0, 1'b1, ok);
    step();
    core_instr = NOP;
    core_pc = 32'd0;
    step();
    core_pc = 32'd4;
    step();
    core_pc = 32'd8;
    core_instr = HALT;
    abort = 1'b1;
    step();
    abort = 1'b0;
    core_instr = NOP;
    n_cmp++;
    if (!ok || done !== 1'b0 || halt_cause !== 2'd0 ||
        core_reset !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ab_state: ok=%b done=%b cause=%0d crst=%b busy=%b rdy=%b want 1 0 0 1 0 0",
        ok, done, halt_cause, core_reset, busy, load_ready);
    end
    n_cmp++;
    if (cycle_count !== 16'd2 || loaded_words !== 7'd3) begin
      n_err++;
      $display("FAIL ab_held: cnt=%0d lw=%0d want 2 3",
        cycle_count, loaded_words);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (load_ready !== 1'b1 || busy !== 1'b1 || loaded_words !== 7'd0) begin
      n_err++;
      $display("FAIL ab_restart: rdy=%b busy=%b lw=%0d want 1 1 0",
        load_ready, busy, loaded_words);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset_midload();
    bit ok;
    wq.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h1000 + i;
      step();
    end
    load_data = 32'h2000;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({load_ready, imem_we, imem_addr, imem_wdata, core_reset,
         busy, done, halt_cause, loaded_words, cycle_count} !==
        {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2'd0, 7'd0,
         16'd0}) begin
      n_err++;
      $display("FAIL rst_mid: rdy=%b we=%b a=%0d wd=%h crst=%b busy=%b lw=%0d",
        load_ready, imem_we, imem_addr, imem_wdata, core_reset,
        busy, loaded_words);
    end
    load_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) img[i] = 32'h3000 + i;
    drive_load(3, 0, 1'b1, ok);
    step();
    n_cmp++;
    if (!ok || wq.size() != 3) begin
      n_err++;
      $display("FAIL rst_reload: ok=%b writes=%0d want 1 3", ok, wq.size());
    end
    for (int i = 0; i < wq.size() && i < 3; i++) begin
      n_cmp++;
      if (wq[i] !== {6'(i), img[i]}) begin
        n_err++;
        $display("FAIL rst_wr%0d: got %h want %h", i, wq[i],
          {6'(i), img[i]});
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    int n, st, ec, en, errs;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 64);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      drive_load(n, $urandom_range(0, 2),
                 (n < 64) ? 1'b1 : 1'($urandom_range(0, 1)), ok);
      step();
      errs = 0;
      for (int i = 0; i < wq.size() && i < n; i++)
        if (wq[i] !== {6'(i), img[i]}) errs++;
      n_cmp++;
      if (!ok || wq.size() != n || errs != 0 ||
          loaded_words !== 7'(n) || core_reset !== 1'b0) begin
        n_err++;
        $display("FAIL rnd%0d_load: ok=%b writes=%0d bad=%0d lw=%0d crst=%b want n=%0d",
          it, ok, wq.size(), errs, loaded_words, core_reset, n);
      end
      for (int c = 0; c < MAXC; c++) begin
        pcs[c] = ($urandom_range(0, 7) == 0) ?
                 32'($urandom_range(0, 4 * n + 8)) : 32'(4 * c);
        ins[c] = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
      end
      drive_run(st);
      model(n, ec, en);
      n_cmp++;
      if (done !== 1'b1 || halt_cause !== 2'(ec) ||
          cycle_count !== 16'(en) || st != en) begin
        n_err++;
        $display("FAIL rnd%0d_run: done=%b cause=%0d cnt=%0d steps=%0d want 1 %0d %0d %0d",
          it, done, halt_cause, cycle_count, st, ec, en, en);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    load_valid = 1'b0; load_last = 1'b0; load_data = 32'h0;
    core_instr = NOP; core_pc = 32'h0;
    test_reset();
    test_halt_instr();
    test_pc_oob();
    test_timeout();
    test_full_load();
    test_abort();
    test_reset_midload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
